// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 display path.
// Contents: controller state encoding, per-device byte/bit counts, index-width helper.
// Used by max7219_frame_arbiter; no ports.
package max7219_pkg;

    // One MAX7219 device is driven with four bytes of frame data.
    localparam int BYTES_PER_DEVICE = 4;
    localparam int BITS_PER_DEVICE  = 8 * BYTES_PER_DEVICE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request after base wins, with wrap.
// Ports: req (requests), base (last winner), mask_base (exclude base from the search),
//        grant (one-hot), grant_idx (winner index), any (some request won).
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    input  logic          mask_base,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Visit base+1, base+2, ... wrapping round; base itself is the last
    // candidate, and is skipped entirely when mask_base is set.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(base) + i;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx] && !(mask_base && (idx == int'(base)))) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/max7219_frame_arbiter.sv
// Shares one cascaded MAX7219 display between NUM_REQ frame producers with round-robin
// arbitration and a minimum per-owner hold time; the winner's frame is latched and handed
// on over valid/ready. Ports: clk, reset_sw (async, active-high), req_valid/req_frame/
// req_ready (producers), frame/frame_valid/frame_ready (display), owner, hold_active.
module max7219_frame_arbiter
    import max7219_pkg::*;
#(
    parameter  int NUM_CASCADES = 4,
    parameter  int NUM_REQ      = 2,
    parameter  int HOLD_CYCLES  = 27_000_000,
    localparam int FB           = BITS_PER_DEVICE * NUM_CASCADES,
    localparam int NB           = BYTES_PER_DEVICE * NUM_CASCADES,
    localparam int OW           = idx_width(NUM_REQ),
    localparam int CW           = idx_width(HOLD_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset_sw,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*FB-1:0] req_frame,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [7:0]            frame [NB],
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [OW-1:0]         owner,
    output logic                  hold_active
);

    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       hold_cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [OW-1:0]       arb_idx;
    logic [OW-1:0]       arb_base;
    logic                arb_any;
    logic                arb_mask;
    logic                load;
    logic                reload;
    logic [OW-1:0]       load_idx;
    logic [FB-1:0]       load_bits;

    // Before the first grant the search starts just after NUM_REQ-1, i.e. at
    // requester 0. In HOLD the arbiter only ever picks a non-owner; the owner's
    // own updates are handled separately below.
    assign arb_base = (state == IDLE) ? LAST_IDX : owner;
    assign arb_mask = (state == HOLD);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .base      (arb_base),
        .mask_base (arb_mask),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        reload    = 1'b0;
        load_idx  = owner;
        req_ready = '0;
        // Gated by reset so no producer sees a handshake while the block is held in reset.
        if (!reset_sw) begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        load      = 1'b1;
                        reload    = 1'b1;
                        load_idx  = arb_idx;
                        req_ready = arb_grant;
                        state_nxt = PUSH;
                    end
                end
                PUSH: begin
                    if (frame_ready) state_nxt = HOLD;
                end
                HOLD: begin
                    // After expiry a waiting non-owner beats an owner update.
                    if ((hold_cnt == '0) && arb_any) begin
                        load      = 1'b1;
                        reload    = 1'b1;
                        load_idx  = arb_idx;
                        req_ready = arb_grant;
                        state_nxt = PUSH;
                    end else if (req_valid[owner]) begin
                        load            = 1'b1;
                        req_ready[owner] = 1'b1;
                        state_nxt       = PUSH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign load_bits = req_frame[int'(load_idx) * FB +: FB];

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            state    <= IDLE;
            owner    <= '0;
            hold_cnt <= '0;
            for (int k = 0; k < NB; k++) frame[k] <= 8'h00;
        end else begin
            state <= state_nxt;
            if (load) begin
                owner <= load_idx;
                // Most significant byte of a producer's word goes to frame[0].
                for (int k = 0; k < NB; k++) frame[k] <= load_bits[FB - 1 - 8 * k -: 8];
            end
            // Owner updates do not reload, so the hold is measured from the grant.
            if (reload) begin
                hold_cnt <= HOLD_INIT;
            end else if ((state != IDLE) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

    assign frame_valid = (state == PUSH);
    assign hold_active = (state != IDLE) && (hold_cnt != '0);

endmodule

// File: tb/tb_max7219_frame_arbiter.sv
// Self-checking bench for max7219_frame_arbiter (1 cascade, 3 requesters, hold of 8).
// Directed scenarios followed by random traffic, checked every cycle against a
// behavioural model of ownership, hold time and the pending display frame.
module tb_max7219_frame_arbiter;

    localparam int NC = 1;
    localparam int NR = 3;
    localparam int HC = 8;

    logic              clk = 1'b0;
    logic              reset_sw;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_frame;
    logic [NR-1:0]     req_ready;
    logic [7:0]        frame [4];
    logic              frame_valid;
    logic              frame_ready;
    logic [1:0]        owner;
    logic              hold_active;

    always #10 clk = ~clk;

    max7219_frame_arbiter #(
        .NUM_CASCADES (NC),
        .NUM_REQ      (NR),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk         (clk),
        .reset_sw    (reset_sw),
        .req_valid   (req_valid),
        .req_frame   (req_frame),
        .req_ready   (req_ready),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .owner       (owner),
        .hold_active (hold_active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the display, how much hold time is left,
    // whether a frame is waiting for the display, and what it shows.
    bit          m_started;
    bit          m_pending;
    int          m_owner;
    int          m_hold;
    int          m_age;
    logic [31:0] m_shown;

    task automatic m_reset();
        m_started = 0;
        m_pending = 0;
        m_owner   = 0;
        m_hold    = 0;
        m_age     = 0;
        m_shown   = '0;
    endtask

    // Which requester should be handed the display this cycle (-1: nobody).
    function automatic int m_winner(input logic [NR-1:0] v);
        if (m_pending) return -1;
        if (!m_started) begin
            for (int j = 0; j < NR; j++) if (v[j]) return j;
            return -1;
        end
        if (m_hold == 0) begin
            for (int s = 1; s < NR; s++) begin
                int j;
                j = (m_owner + s) % NR;
                if (v[j]) return j;
            end
        end
        if (v[m_owner]) return m_owner;
        return -1;
    endfunction

    function automatic logic [31:0] dut_frame();
        return {frame[0], frame[1], frame[2], frame[3]};
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    // The display accepts a frame on its third cycle of valid unless stalled.
    task automatic cycle(input logic [NR-1:0] v, input bit stall);
        int          w;
        logic [NR-1:0] exp_rdy;
        req_valid   = v;
        frame_ready = m_pending && (m_age >= 2) && !stall;
        @(negedge clk);
        w       = m_winner(v);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready",   req_ready,   exp_rdy);
        check("frame_valid", frame_valid, m_pending);
        check("frame",       dut_frame(), m_shown);
        check("owner",       owner,       m_owner);
        check("hold_active", hold_active, m_started && (m_hold != 0));
        if (w >= 0) begin
            if (!m_started || (w != m_owner)) m_hold = HC - 1;
            else if (m_hold > 0)              m_hold = m_hold - 1;
            m_shown   = req_frame[w * 32 +: 32];
            m_owner   = w;
            m_started = 1;
            m_pending = 1;
            m_age     = 0;
        end else begin
            if (m_started && (m_hold > 0)) m_hold = m_hold - 1;
            if (m_pending) begin
                if (frame_ready) m_pending = 0;
                else             m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && m_pending; i++) cycle(3'b000, 0);
    endtask

    initial begin
        reset_sw    = 1'b0;
        req_valid   = '0;
        frame_ready = 1'b0;
        req_frame   = '0;
        m_reset();
        #1 reset_sw = 1'b1;
        req_valid   = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",   req_ready,   3'b000);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_frame",       dut_frame(), 32'h0);
        check("rst_owner",       owner,       2'd0);
        check("rst_hold_active", hold_active, 1'b0);
        reset_sw = 1'b0;

        // First grant goes to the only requester, frame bytes in order.
        req_frame = {32'h11223344, 32'hA0B1C2D3, 32'h55667788};
        cycle(3'b010, 0);
        check("s1_owner",       owner,       2'd1);
        check("s1_frame",       dut_frame(), 32'hA0B1C2D3);
        check("s1_frame_valid", frame_valid, 1'b1);
        repeat (2) cycle(3'b000, 0);

        // Others wait out the hold; at expiry req 2 (after 1) wins over req 0.
        for (int i = 0; i < 20 && m_owner != 2; i++) cycle(3'b101, 0);
        check("s2_owner", owner, 2'd2);

        // Owner update mid-hold does not extend the hold.
        repeat (3) cycle(3'b000, 0);
        req_frame[64 +: 32] = 32'hDEADBEEF;
        cycle(3'b101, 0);
        repeat (4) cycle(3'b001, 0);
        check("s3_owner", owner, 2'd0);

        // Expired hold: a waiting non-owner beats the owner's own update.
        repeat (10) cycle(3'b000, 0);
        cycle(3'b011, 0);
        check("s4a_owner", owner, 2'd1);
        repeat (10) cycle(3'b000, 0);
        cycle(3'b011, 0);
        check("s4b_owner", owner, 2'd0);

        // Display stalls for 20 cycles: frame held, no producer handshakes.
        repeat (10) cycle(3'b000, 0);
        req_frame = {32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4};
        cycle(3'b111, 0);
        repeat (20) cycle(3'b111, 1);
        drain();

        // Reset between clock edges in the middle of a push.
        cycle(3'b111, 0);
        req_valid = 3'b000;
        @(negedge clk);
        #2 reset_sw = 1'b1;
        #1;
        check("s6_frame_valid", frame_valid, 1'b0);
        check("s6_frame",       dut_frame(), 32'h0);
        check("s6_owner",       owner,       2'd0);
        check("s6_hold_active", hold_active, 1'b0);
        m_reset();
        #2 reset_sw = 1'b0;
        @(posedge clk);
        #1;
        cycle(3'b111, 0);
        check("s6_first_owner", owner, 2'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [NR-1:0] v;
            req_frame = {$urandom, $urandom, $urandom};
            v = ($urandom_range(0, 3) == 0) ? 3'b000 : NR'($urandom_range(0, 7));
            cycle(v, $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
